// File: rtl/pulse_width_decoder_if.sv
// Result handshake bundle for the pulse width decoder.
// The decoder drives results through the master side; the consumer owns count_ready.
interface pulse_width_decoder_if;
  logic        count_ready;
  logic [31:0] count_data;
  logic        count_valid;
  logic        count_saturated;
  logic        zero_frame;
  logic        line_stuck;
  logic [15:0] dropped_frames;

  modport master (
    input  count_ready,
    output count_data,
    output count_valid,
    output count_saturated,
    output zero_frame,
    output line_stuck,
    output dropped_frames
  );

  modport slave (
    output count_ready,
    input  count_data,
    input  count_valid,
    input  count_saturated,
    input  zero_frame,
    input  line_stuck,
    input  dropped_frames
  );
endinterface

// File: rtl/pulse_width_decoder.sv
// Pulse width decoder: measures the high width of each frame on the photon-count
// pulse line and presents one 32-bit count per frame on a valid/ready handshake.
// A watchdog reports a zero-count frame when no pulse arrives within FRAME_TIMEOUT
// cycles of the last frame start.
module pulse_width_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int MAX_WIDTH     = 50000000,
  parameter int FRAME_TIMEOUT = 50500000
) (
  input  logic                  clock_50_mhz,
  input  logic                  reset,
  input  logic                  pulse_in,
  pulse_width_decoder_if.master count_bus
);

  localparam logic [31:0] MAX_W        = 32'(MAX_WIDTH);
  localparam logic [31:0] TIMEOUT_LAST = 32'(FRAME_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_in;
  logic                   sync_q;
  logic                   sync_q2;
  logic                   rise;
  logic                   fall;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] width_q;
  logic [31:0] width_d;
  logic [31:0] frame_timer_q;
  logic [31:0] frame_timer_d;

  logic        emit;
  logic [31:0] emit_data;
  logic        emit_sat;
  logic        emit_zero;

  logic        slot_free;
  logic [31:0] data_q;
  logic        valid_q;
  logic        sat_q;
  logic        zero_q;
  logic [15:0] dropped_q;

  assign sync_in = sync_chain[SYNC_STAGES-1];

  // Edges are taken between the registered copy and its own delayed copy, which
  // puts the frame result SYNC_STAGES+1 edges after the first low sample.
  assign rise = sync_q & ~sync_q2;
  assign fall = ~sync_q & sync_q2;

  // Input synchroniser plus the two-deep registered copy used for edge detection.
  always_ff @(posedge clock_50_mhz or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
      sync_q     <= 1'b0;
      sync_q2    <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], pulse_in};
      sync_q     <= sync_in;
      sync_q2    <= sync_q;
    end
  end

  // FSM state, width counter and frame watchdog registers.
  always_ff @(posedge clock_50_mhz or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      width_q       <= '0;
      frame_timer_q <= '0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      frame_timer_q <= frame_timer_d;
    end
  end

  // Next-state logic: start on a rise, emit on a fall or a watchdog expiry in IDLE.
  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    frame_timer_d = (frame_timer_q == TIMEOUT_LAST) ? frame_timer_q : frame_timer_q + 32'd1;
    emit          = 1'b0;
    emit_data     = '0;
    emit_sat      = 1'b0;
    emit_zero     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d       = MEASURE;
          width_d       = 32'd1;
          frame_timer_d = '0;
        end else if (frame_timer_q == TIMEOUT_LAST) begin
          emit          = 1'b1;
          emit_zero     = 1'b1;
          frame_timer_d = '0;
        end
      end
      MEASURE: begin
        if (fall) begin
          emit      = 1'b1;
          emit_data = width_q;
          emit_sat  = (width_q == MAX_W);
          state_d   = IDLE;
        end else if (width_q != MAX_W) begin
          width_d = width_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign slot_free = ~valid_q | count_bus.count_ready;

  // Output slot: load on emit when free, otherwise hold the old result and count the loss.
  always_ff @(posedge clock_50_mhz or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      zero_q    <= 1'b0;
      dropped_q <= '0;
    end else begin
      if (emit && slot_free) begin
        data_q  <= emit_data;
        sat_q   <= emit_sat;
        zero_q  <= emit_zero;
        valid_q <= 1'b1;
      end else if (valid_q && count_bus.count_ready) begin
        valid_q <= 1'b0;
      end
      if (emit && !slot_free && (dropped_q != 16'hFFFF)) begin
        dropped_q <= dropped_q + 16'd1;
      end
    end
  end

  assign count_bus.count_data      = data_q;
  assign count_bus.count_valid     = valid_q;
  assign count_bus.count_saturated = sat_q;
  assign count_bus.zero_frame      = zero_q;
  assign count_bus.dropped_frames  = dropped_q;
  assign count_bus.line_stuck      = (state_q == MEASURE) && (width_q == MAX_W);

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Testbench for pulse_width_decoder: directed pulses with hand-computed results,
// checked by a queue-based scoreboard and a monitor on the result handshake.
module tb_pulse_width_decoder;

  logic clock_50_mhz;
  logic reset;
  logic pulse_in;

  pulse_width_decoder_if bus ();

  pulse_width_decoder #(
    .SYNC_STAGES  (2),
    .MAX_WIDTH    (64),
    .FRAME_TIMEOUT(100)
  ) dut (
    .clock_50_mhz(clock_50_mhz),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .count_bus   (bus.master)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
    logic        zero;
  } result_t;

  result_t exp_q[$];
  result_t mon_exp;
  int      checks = 0;
  int      errors = 0;

  initial clock_50_mhz = 1'b0;
  always #5 clock_50_mhz = ~clock_50_mhz;

  // Compare one value and report a mismatch.
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance to one time unit after the next falling edge.
  task automatic step();
    @(negedge clock_50_mhz);
    #1;
  endtask

  task automatic push_expected(input logic [31:0] data, input logic sat, input logic zero);
    result_t r;
    r.data = data;
    r.sat  = sat;
    r.zero = zero;
    exp_q.push_back(r);
  endtask

  // High level on pulse_in covering exactly n rising edges.
  task automatic apply_stimulus(input int n);
    pulse_in = 1'b1;
    repeat (n) step();
    pulse_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) step();
    check_output("drain_pending_results", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_count_data"}, bus.count_data, 32'd0);
    check_output({tag, "_count_valid"}, 32'(bus.count_valid), 32'd0);
    check_output({tag, "_count_saturated"}, 32'(bus.count_saturated), 32'd0);
    check_output({tag, "_zero_frame"}, 32'(bus.zero_frame), 32'd0);
    check_output({tag, "_line_stuck"}, 32'(bus.line_stuck), 32'd0);
    check_output({tag, "_dropped_frames"}, 32'(bus.dropped_frames), 32'd0);
  endtask

  // Monitor: every transfer pops the oldest expected result and compares it.
  always @(negedge clock_50_mhz) begin
    #2;
    if (!reset && bus.count_valid && bus.count_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got data=%0d sat=%0d zero=%0d, expected none",
                 bus.count_data, bus.count_saturated, bus.zero_frame);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("result_data", bus.count_data, mon_exp.data);
        check_output("result_saturated", 32'(bus.count_saturated), 32'(mon_exp.sat));
        check_output("result_zero_frame", 32'(bus.zero_frame), 32'(mon_exp.zero));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    reset           = 1'b1;
    pulse_in        = 1'b0;
    bus.count_ready = 1'b1;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Single 37-cycle frame: valid for one cycle, 3 edges after the first low sample.
    $display("[TB] single frame");
    do_reset();
    push_expected(32'd37, 1'b0, 1'b0);
    apply_stimulus(37);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_output($sformatf("valid_after_fall_edge_%0d", k - 1), 32'(bus.count_valid), 32'(k == 4));
    end
    wait_drain(10);

    // 1-cycle pulse, one low cycle, 2-cycle pulse.
    $display("[TB] minimum and adjacent pulses");
    do_reset();
    push_expected(32'd1, 1'b0, 1'b0);
    push_expected(32'd2, 1'b0, 1'b0);
    apply_stimulus(1);
    step();
    apply_stimulus(2);
    wait_drain(20);
    check_output("adjacent_dropped_frames", 32'(bus.dropped_frames), 32'd0);

    // Line idle after reset: zero frames at edges 100 and 200; a pulse whose
    // synchronised rise meets the third timeout suppresses that zero frame.
    $display("[TB] zero frames");
    reset = 1'b1;
    step();
    reset = 1'b0;
    push_expected(32'd0, 1'b0, 1'b1);
    push_expected(32'd0, 1'b0, 1'b1);
    push_expected(32'd6, 1'b0, 1'b0);
    for (int k = 1; k <= 310; k++) begin
      step();
      if (k == 296) pulse_in = 1'b1;
      if (k == 302) pulse_in = 1'b0;
      if (k == 99 || k == 100 || k == 101 || k == 199 || k == 200 || k == 201 ||
          k == 299 || k == 300 || k == 301) begin
        check_output($sformatf("zero_frame_valid_edge_%0d", k), 32'(bus.count_valid),
                     32'(k == 100 || k == 200));
      end
    end
    wait_drain(10);

    // 80-cycle pulse saturates the width counter at 64.
    $display("[TB] saturation");
    do_reset();
    push_expected(32'd64, 1'b1, 1'b0);
    pulse_in = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (i == 50) check_output("line_stuck_before_max", 32'(bus.line_stuck), 32'd0);
      if (i == 75) check_output("line_stuck_at_max", 32'(bus.line_stuck), 32'd1);
    end
    pulse_in = 1'b0;
    wait_drain(10);
    step();
    check_output("line_stuck_after_fall", 32'(bus.line_stuck), 32'd0);

    // Three 5-cycle pulses against a stalled consumer.
    $display("[TB] back-pressure");
    do_reset();
    bus.count_ready = 1'b0;
    push_expected(32'd5, 1'b0, 1'b0);
    apply_stimulus(5);
    repeat (3) step();
    apply_stimulus(5);
    repeat (3) step();
    apply_stimulus(5);
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      check_output("held_valid", 32'(bus.count_valid), 32'd1);
      check_output("held_data", bus.count_data, 32'd5);
      step();
    end
    check_output("dropped_frames", 32'(bus.dropped_frames), 32'd2);
    bus.count_ready = 1'b1;
    step();
    check_output("valid_after_transfer", 32'(bus.count_valid), 32'd0);
    wait_drain(5);

    // Reset in the 10th cycle of a 40-cycle pulse, then a clean 12-cycle pulse.
    $display("[TB] reset mid-frame");
    push_expected(32'd12, 1'b0, 1'b0);
    step();
    step();
    pulse_in = 1'b1;
    repeat (9) step();
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (31) step();
    pulse_in = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    repeat (3) step();
    apply_stimulus(12);
    wait_drain(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
